// File: rtl/spi_pkg.sv
// Shared definitions for the SPI slave port: FSM encoding, spicr bit
// positions and the data word width.
package spi_pkg;

   localparam int SPI_DW   = 8;
   localparam int CPOL_BIT = 1;
   localparam int CPHA_BIT = 0;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_XFER = 1'b1
   } spi_state_t;

endpackage

// File: rtl/spi_slave_if_if.sv
// Host-side bundle of the SPI slave port.
//
// Handshake: tx_data is written into the one-entry holding buffer on any
// clk edge where tx_valid && tx_ready are both 1; tx_ready is 1 exactly when
// the buffer is empty. rx_valid is a one-cycle pulse with no back-pressure:
// rx_data is updated on that cycle and then held until the next byte.
// dbg_state mirrors the slave FSM state for observation.
interface spi_slave_if_if
   import spi_pkg::*;
();

   logic [1:0]        spicr;
   logic [SPI_DW-1:0] tx_data;
   logic              tx_valid;
   logic              tx_ready;
   logic [SPI_DW-1:0] rx_data;
   logic              rx_valid;
   logic              underrun;
   logic              busy;
   spi_state_t        dbg_state;

   modport master (
      output spicr, tx_data, tx_valid,
      input  tx_ready, rx_data, rx_valid, underrun, busy, dbg_state
   );

   modport slave (
      input  spicr, tx_data, tx_valid,
      output tx_ready, rx_data, rx_valid, underrun, busy, dbg_state
   );

endinterface

// File: rtl/spi_sync_edge.sv
// N-stage synchroniser for an asynchronous input, followed by registered
// rise/fall pulses. All flops clear to 0 so that a line already low at
// reset release never produces a spurious falling edge.
module spi_sync_edge #(
   parameter int N = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic i_d,
   output logic o_rise,
   output logic o_fall
);

   logic [N-1:0] r_sync;
   logic         r_prev;
   logic         r_rise;
   logic         r_fall;

   // Synchronise, remember the previous level and register the edge pulses.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_sync <= '0;
         r_prev <= 1'b0;
         r_rise <= 1'b0;
         r_fall <= 1'b0;
      end else begin
         r_sync <= {r_sync[N-2:0], i_d};
         r_prev <= r_sync[N-1];
         r_rise <= r_sync[N-1] & ~r_prev;
         r_fall <= ~r_sync[N-1] & r_prev;
      end
   end

   assign o_rise = r_rise;
   assign o_fall = r_fall;

endmodule

// File: rtl/spi_slave_if.sv
// SPI slave port: oversamples SCK/MOSI/CS_ in the clk domain, deserialises
// MOSI into bytes and serialises bytes from a one-entry holding buffer onto
// MISO. All four CPOL/CPHA modes, MSB first.
module spi_slave_if
   import spi_pkg::*;
#(
   parameter int SYNC_STAGES = 2
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          sck,
   input  logic          mosi,
   input  logic          cs_,
   output logic          miso,
   output logic          miso_oe,
   spi_slave_if_if.slave host
);

   spi_state_t              r_state;
   spi_state_t              w_state_nxt;
   logic [SYNC_STAGES-1:0]  r_mosi_sync;
   logic                    w_mosi_s;
   logic                    w_sck_rise;
   logic                    w_sck_fall;
   logic                    w_cs_rise;
   logic                    w_cs_fall;
   logic                    r_cpol;
   logic                    r_cpha;
   logic                    w_lead;
   logic                    w_trail;
   logic                    w_sample_edge;
   logic                    w_shift_edge;
   logic                    w_sample;
   logic                    w_load;
   logic                    w_shift;
   logic                    w_start;
   logic                    w_stop;
   logic [2:0]              r_bit_cnt;
   logic                    r_load_pend;
   logic [SPI_DW-2:0]       r_rx_sr;
   logic [SPI_DW-1:0]       r_tx_sr;
   logic [SPI_DW-1:0]       r_buf;
   logic                    r_buf_full;
   logic [SPI_DW-1:0]       r_rx_data;
   logic                    r_rx_valid;
   logic                    r_underrun;

   spi_sync_edge #(.N(SYNC_STAGES)) u_sck_sync (
      .clk    (clk),
      .reset  (reset),
      .i_d    (sck),
      .o_rise (w_sck_rise),
      .o_fall (w_sck_fall)
   );

   spi_sync_edge #(.N(SYNC_STAGES)) u_cs_sync (
      .clk    (clk),
      .reset  (reset),
      .i_d    (cs_),
      .o_rise (w_cs_rise),
      .o_fall (w_cs_fall)
   );

   // MOSI only needs its level; no edge detection.
   always_ff @(posedge clk) begin
      if (reset) r_mosi_sync <= '0;
      else       r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], mosi};
   end
   assign w_mosi_s = r_mosi_sync[SYNC_STAGES-1];

   // Leading edge leaves the idle level CPOL; CPHA picks which edge samples.
   assign w_lead        = r_cpol ? w_sck_fall : w_sck_rise;
   assign w_trail       = r_cpol ? w_sck_rise : w_sck_fall;
   assign w_sample_edge = r_cpha ? w_trail : w_lead;
   assign w_shift_edge  = r_cpha ? w_lead  : w_trail;

   // FSM state register.
   always_ff @(posedge clk) begin
      if (reset) r_state <= ST_IDLE;
      else       r_state <= w_state_nxt;
   end

   // Next state and per-cycle datapath strobes; a cs_ rise suppresses a
   // coincident shift/load so the buffer is left untouched on abort.
   always_comb begin
      w_state_nxt = r_state;
      w_sample    = 1'b0;
      w_load      = 1'b0;
      w_shift     = 1'b0;
      w_start     = 1'b0;
      w_stop      = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_cs_fall) begin
               w_state_nxt = ST_XFER;
               w_start     = 1'b1;
               w_load      = ~host.spicr[CPHA_BIT];
            end
         end
         ST_XFER: begin
            w_sample = w_sample_edge;
            w_load   = w_shift_edge & ~w_cs_rise & r_load_pend;
            w_shift  = w_shift_edge & ~w_cs_rise & ~r_load_pend;
            if (w_cs_rise) begin
               w_state_nxt = ST_IDLE;
               w_stop      = 1'b1;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // Datapath: mode latch, RX shifter, TX shifter and holding buffer.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_cpol      <= 1'b0;
         r_cpha      <= 1'b0;
         r_bit_cnt   <= 3'd0;
         r_load_pend <= 1'b0;
         r_rx_sr     <= '0;
         r_tx_sr     <= '0;
         r_buf       <= '0;
         r_buf_full  <= 1'b0;
         r_rx_data   <= '0;
         r_rx_valid  <= 1'b0;
         r_underrun  <= 1'b0;
      end else begin
         r_rx_valid <= 1'b0;
         r_underrun <= 1'b0;
         if (r_state == ST_IDLE) begin
            r_cpol <= host.spicr[CPOL_BIT];
            r_cpha <= host.spicr[CPHA_BIT];
         end
         if (w_sample) begin
            r_rx_sr   <= {r_rx_sr[SPI_DW-3:0], w_mosi_s};
            r_bit_cnt <= r_bit_cnt + 3'd1;
            if (r_bit_cnt == 3'd7) begin
               r_rx_data   <= {r_rx_sr, w_mosi_s};
               r_rx_valid  <= 1'b1;
               r_load_pend <= 1'b1;
            end
         end
         if (w_load) begin
            r_load_pend <= 1'b0;
            if (r_buf_full) begin
               r_tx_sr    <= r_buf;
               r_buf_full <= 1'b0;
            end else begin
               r_tx_sr    <= '0;
               r_underrun <= 1'b1;
            end
         end else if (w_shift) begin
            r_tx_sr <= r_tx_sr << 1;
         end
         // Write acceptance uses the pre-load buffer state.
         if (host.tx_valid && !r_buf_full) begin
            r_buf      <= host.tx_data;
            r_buf_full <= 1'b1;
         end
         if (w_start) begin
            r_bit_cnt   <= 3'd0;
            r_load_pend <= host.spicr[CPHA_BIT];
         end
         if (w_stop) begin
            r_bit_cnt   <= 3'd0;
            r_load_pend <= 1'b0;
         end
      end
   end

   assign miso_oe        = (r_state == ST_XFER);
   assign miso           = miso_oe & r_tx_sr[SPI_DW-1];
   assign host.busy      = (r_state == ST_XFER);
   assign host.tx_ready  = ~r_buf_full;
   assign host.rx_data   = r_rx_data;
   assign host.rx_valid  = r_rx_valid;
   assign host.underrun  = r_underrun;
   assign host.dbg_state = r_state;

endmodule

// File: tb/tb_spi_slave_if.sv
// Bench for spi_slave_if: a reference SPI master drives the pins, a host
// driver feeds the TX buffer, and a scoreboard checks received bytes.
module tb_spi_slave_if;
   import spi_pkg::*;

   localparam int SYNC = 2;
   localparam int H    = SYNC + 3;   // sck half-period in clk cycles

   typedef struct packed {
      logic [1:0]  mode;
      logic [1:0]  nbytes;
      logic [23:0] tx;          // bytes the host loads, MSB byte first
      logic [23:0] rx;          // bytes the master sends, MSB byte first
      logic [1:0]  exp_under;
   } vec_t;

   logic clk = 1'b0;
   logic reset;
   logic sck;
   logic mosi;
   logic cs_;
   logic miso;
   logic miso_oe;

   spi_slave_if_if host ();

   spi_slave_if #(.SYNC_STAGES(SYNC)) dut (
      .clk     (clk),
      .reset   (reset),
      .sck     (sck),
      .mosi    (mosi),
      .cs_     (cs_),
      .miso    (miso),
      .miso_oe (miso_oe),
      .host    (host)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;
   int n_rxv   = 0;
   int n_under = 0;

   logic [7:0] exp_q[$];
   logic [7:0] m_tx [0:255];
   logic [7:0] m_rx [0:255];
   logic [7:0] h_tx [0:255];
   vec_t       vecs [0:3];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- scoreboard / monitor ----------------
   always @(negedge clk) begin
      if (host.rx_valid === 1'b1) begin
         n_rxv++;
         if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL rx_unexpected: got 0x%0h, expected no byte", host.rx_data);
         end else begin
            check("rx_byte", host.rx_data, exp_q.pop_front());
         end
      end
      if (host.underrun === 1'b1) n_under++;
   end

   // ---------------- driver tasks ----------------
   task automatic host_write(input logic [7:0] d);
      int t;
      t = 0;
      while (host.tx_ready !== 1'b1 && t < 4000) begin
         @(negedge clk);
         t++;
      end
      check("tx_ready_wait", (t < 4000), 1);
      host.tx_data  = d;
      host.tx_valid = 1'b1;
      @(negedge clk);
      host.tx_valid = 1'b0;
   endtask

   // Reference master: sends m_tx bit-serially, captures MISO into m_rx.
   task automatic spi_frame(input logic [1:0] mode, input int nbits);
      logic cpol;
      logic cpha;
      cpol = mode[1];
      cpha = mode[0];
      for (int k = 0; k < 256; k++) m_rx[k] = 8'h00;
      sck        = cpol;
      host.spicr = mode;
      repeat (10) @(negedge clk);
      cs_ = 1'b0;
      if (!cpha) mosi = m_tx[0][7];
      repeat (H) @(negedge clk);
      for (int i = 0; i < nbits; i++) begin
         sck = ~cpol;
         if (cpha) mosi = m_tx[i/8][7 - (i % 8)];
         else      m_rx[i/8] = {m_rx[i/8][6:0], miso};
         repeat (H) @(negedge clk);
         sck = cpol;
         if (cpha)            m_rx[i/8] = {m_rx[i/8][6:0], miso};
         else if (i + 1 < nbits) mosi = m_tx[(i+1)/8][7 - ((i+1) % 8)];
         repeat (H) @(negedge clk);
      end
      cs_ = 1'b1;
      repeat (4 * H) @(negedge clk);
   endtask

   task automatic run_burst(input logic [1:0] mode, input int n);
      n_rxv   = 0;
      n_under = 0;
      for (int k = 0; k < n; k++) exp_q.push_back(m_tx[k]);
      host_write(h_tx[0]);
      fork
         spi_frame(mode, n * 8);
         begin
            for (int k = 1; k < n; k++) host_write(h_tx[k]);
         end
      join
   endtask

   task automatic check_burst(input int n, input int exp_under);
      for (int k = 0; k < n; k++) check("master_rx", m_rx[k], h_tx[k]);
      check("rx_count", n_rxv, n);
      check("rx_pending", exp_q.size(), 0);
      check("underrun_count", n_under, exp_under);
      check("busy_after", host.busy, 0);
      check("miso_oe_after", miso_oe, 0);
      check("tx_ready_after", host.tx_ready, 1);
      check("rx_data_last", host.rx_data, m_tx[n-1]);
   endtask

   // ---------------- watchdog ----------------
   initial begin
      #4000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- main test ----------------
   initial begin
      reset         = 1'b1;
      sck           = 1'b0;
      mosi          = 1'b0;
      cs_           = 1'b1;
      host.spicr    = 2'd0;
      host.tx_data  = 8'h00;
      host.tx_valid = 1'b0;

      vecs[0] = '{mode: 2'd0, nbytes: 2'd1, tx: 24'hA50000, rx: 24'h3C0000, exp_under: 2'd1};
      vecs[1] = '{mode: 2'd1, nbytes: 2'd3, tx: 24'h0180FF, rx: 24'h55AA0F, exp_under: 2'd0};
      vecs[2] = '{mode: 2'd2, nbytes: 2'd3, tx: 24'h0180FF, rx: 24'h55AA0F, exp_under: 2'd1};
      vecs[3] = '{mode: 2'd3, nbytes: 2'd3, tx: 24'h0180FF, rx: 24'h55AA0F, exp_under: 2'd0};

      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);

      // Reset state
      check("rst_miso", miso, 0);
      check("rst_miso_oe", miso_oe, 0);
      check("rst_tx_ready", host.tx_ready, 1);
      check("rst_rx_data", host.rx_data, 8'h00);
      check("rst_rx_valid", host.rx_valid, 0);
      check("rst_underrun", host.underrun, 0);
      check("rst_busy", host.busy, 0);
      check("rst_state", 32'(host.dbg_state), 32'(ST_IDLE));

      // Table-driven frames in all four modes
      for (int v = 0; v < 4; v++) begin
         for (int k = 0; k < 3; k++) begin
            h_tx[k] = vecs[v].tx[23 - 8*k -: 8];
            m_tx[k] = vecs[v].rx[23 - 8*k -: 8];
         end
         run_burst(vecs[v].mode, int'(vecs[v].nbytes));
         check_burst(int'(vecs[v].nbytes), int'(vecs[v].exp_under));
      end

      // Underrun and a write held while the buffer is full
      host_write(8'h5A);
      host.tx_data  = 8'h99;
      host.tx_valid = 1'b1;
      repeat (4) @(negedge clk);
      check("hold_tx_ready", host.tx_ready, 0);
      host.tx_valid = 1'b0;
      @(negedge clk);
      m_tx[0] = 8'h12;
      m_tx[1] = 8'h34;
      n_rxv   = 0;
      n_under = 0;
      exp_q.push_back(8'h12);
      exp_q.push_back(8'h34);
      spi_frame(2'd1, 16);
      check("ur_master_b0", m_rx[0], 8'h5A);
      check("ur_master_b1", m_rx[1], 8'h00);
      check("ur_count", n_under, 1);
      check("ur_rx_count", n_rxv, 2);
      check("ur_rx_data", host.rx_data, 8'h34);

      // cs_ rises after 5 bits: frame discarded
      host_write(8'h77);
      m_tx[0] = 8'hFF;
      n_rxv   = 0;
      n_under = 0;
      spi_frame(2'd0, 5);
      check("abort_rx_count", n_rxv, 0);
      check("abort_busy", host.busy, 0);
      check("abort_rx_data", host.rx_data, 8'h34);
      check("abort_master_bits", m_rx[0], 8'h0E);
      check("abort_underrun", n_under, 0);

      // Next frame received correctly from bit 7
      h_tx[0] = 8'hC3;
      m_tx[0] = 8'h96;
      run_burst(2'd0, 1);
      check_burst(1, 1);

      // Reset pulse mid-byte
      host_write(8'hE1);
      m_tx[0] = 8'h81;
      n_rxv   = 0;
      n_under = 0;
      fork
         spi_frame(2'd3, 8);
         begin
            repeat (40) @(negedge clk);
            host_write(8'h44);
            @(negedge clk);
            check("mid_busy", host.busy, 1);
            check("mid_miso_oe", miso_oe, 1);
            check("mid_tx_ready", host.tx_ready, 0);
            reset = 1'b1;
            @(negedge clk);
            reset = 1'b0;
            check("mrst_miso", miso, 0);
            check("mrst_miso_oe", miso_oe, 0);
            check("mrst_tx_ready", host.tx_ready, 1);
            check("mrst_rx_data", host.rx_data, 8'h00);
            check("mrst_rx_valid", host.rx_valid, 0);
            check("mrst_underrun", host.underrun, 0);
            check("mrst_busy", host.busy, 0);
         end
      join
      check("mrst_no_rx", n_rxv, 0);
      check("mrst_no_underrun", n_under, 0);
      check("mrst_idle", host.busy, 0);

      // Full frame after reset with a different mode
      h_tx[0] = 8'h3A;
      m_tx[0] = 8'hC5;
      run_burst(2'd2, 1);
      check_burst(1, 1);

      // 256 random bytes at f_clk/10, 64 per mode
      for (int m = 0; m < 4; m++) begin
         for (int k = 0; k < 64; k++) begin
            h_tx[k] = 8'($urandom_range(0, 255));
            m_tx[k] = 8'($urandom_range(0, 255));
         end
         run_burst(2'(m), 64);
         check_burst(64, (m % 2 == 0) ? 1 : 0);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/spi_slave_if.md
# spi_slave_if

SPI slave (responder) port for SPI links driven by the team's SPI master. It oversamples an external master's SCK, MOSI and CS_ in the system clock domain, deserialises MOSI into bytes for the local host and serialises host bytes onto MISO. It supports all four CPOL/CPHA modes, MSB first, with an 8-bit data word and a one-entry TX holding buffer.

## Interface
- SYNC_STAGES, 2, synchroniser depth for sck, mosi and cs_ (legal range 2..3).
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high; clears all state on the clk edge where it is high.
- spicr  in  2  bit1 = CPOL, bit0 = CPHA; latched only while in IDLE.
- sck  in  1  SPI clock from the master, asynchronous.
- mosi  in  1  master-out data, asynchronous.
- cs_  in  1  active-low chip select, asynchronous.
- miso  out  1  slave-out data; equals tx_sr[7] when miso_oe = 1, otherwise 0.
- miso_oe  out  1  MISO output enable; 1 only while in XFER.
- tx_data  in  8  byte to transmit.
- tx_valid  in  1  write strobe; accepted when tx_valid && tx_ready.
- tx_ready  out  1  holding buffer empty.
- rx_data  out  8  last complete received byte; held until the next byte completes.
- rx_valid  out  1  one-cycle pulse when rx_data updates.
- underrun  out  1  one-cycle pulse when a byte load finds the holding buffer empty; 0x00 is sent instead.
- busy  out  1  1 while in XFER.

## Operation
- sck, mosi and cs_ each pass through SYNC_STAGES flops. Edges are detected on the synchronised sck and cs_.
- Leading edge is the sck transition away from CPOL. Trailing edge is the transition back to CPOL.
- Sample and shift edges:
  - CPHA = 0: sample on the leading edge, shift on the trailing edge.
  - CPHA = 1: shift on the leading edge, sample on the trailing edge.
- States: IDLE and XFER.
- IDLE:
  - spicr is latched every cycle; miso_oe = 0.
  - On a synchronised cs_ fall, go to XFER and set bit_cnt = 0.
  - If CPHA = 0, load tx_sr from the buffer immediately.
  - If CPHA = 1, set load_pend = 1 so the first shift edge performs the load.
- XFER, sample edge:
  - rx_sr <= {rx_sr[6:0], mosi_sync}, and bit_cnt increments (3-bit, wraps 7 to 0).
  - On the sample edge where bit_cnt is 7: rx_data <= {rx_sr[6:0], mosi_sync}, pulse rx_valid, set load_pend = 1.
- XFER, shift edge:
  - If load_pend = 1: load tx_sr from the buffer and clear load_pend.
  - Otherwise: tx_sr <= tx_sr << 1.
- Load from buffer:
  - Buffer full: tx_sr <= buffer, buffer marked empty, tx_ready = 1 from the next cycle.
  - Buffer empty: tx_sr <= 0x00 and underrun pulses.
- Buffer write: accepted when tx_valid && tx_ready. A write and a load in the same cycle: the load sees the old state, so the write is accepted only if tx_ready was already 1.
- Synchronised cs_ rise in XFER (including mid-byte):
  - Go to IDLE, clear bit_cnt and load_pend; partial bits are discarded with no rx_valid.
  - The buffer is not modified.
- A sampled byte that completes on the same cycle cs_ rise is detected still produces rx_valid. The sample edge takes priority over the cs_ rise.
- sck edges in IDLE are ignored.
- Reset values: miso 0, miso_oe 0, tx_ready 1, rx_data 0x00, rx_valid 0, underrun 0, busy 0, state IDLE.

## Timing
- Pin-to-action latency is SYNC_STAGES+1 clk, covering the synchroniser plus the edge-detect register.
- miso changes SYNC_STAGES+2 clk after a shift edge at the pin.
- rx_valid rises SYNC_STAGES+2 clk after the 8th sample edge at the pin.
- The sck half-period must be at least SYNC_STAGES+3 clk. For SYNC_STAGES = 2 this means f_sck ≤ f_clk/10.
- For CPHA = 0, cs_ fall to first sck edge must be at least SYNC_STAGES+3 clk.
- cs_ high time between frames must be at least 2 clk.
- Reset mid-transfer aborts the frame on the next clk edge. The master's remaining edges are then ignored until the next cs_ fall.

## Structure
- Shared package spi_pkg:
  - state encoding constants ST_IDLE and ST_XFER;
  - CPOL_BIT = 1 and CPHA_BIT = 0;
  - SPI_DW = 8.
- Sub-module spi_sync_edge: an N-stage synchroniser with registered rise/fall pulses. It is instantiated for sck and cs_; mosi uses its synchronised output only.
- Everything else lives in the top-level block.

## Test plan
- Mode 0, buffer preloaded with 0xA5, master sends 0x3C: master receives 0xA5; rx_data = 0x3C with a single rx_valid; tx_ready returns to 1.
- Modes 1, 2 and 3, each with a 3-byte burst under one cs_ (TX 0x01/0x80/0xFF, RX 0x55/0xAA/0x0F): bit-exact both directions with 3 rx_valid pulses.
- Buffer empty at byte load: MISO carries 0x00 and underrun pulses once. A tx_valid held while tx_ready = 0 is not accepted, and the buffer keeps its previous value.
- cs_ rises after 5 bits: no rx_valid, busy drops, rx_data is unchanged. The next frame is received correctly from bit 7.
- reset asserted for 1 clk mid-byte: all outputs return to reset values the next cycle. A later full frame works, with spicr re-latched.
- sck at f_clk/10 with cs_ setup exactly SYNC_STAGES+3 clk: no bit errors over 256 random bytes, compared against a reference master model.
